// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for EX (div.w/mod.w/div.wu/mod.wu) with valid/ready in and out.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;      // dividend; quotient bits shift in at the LSB
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_q;
    logic             sgn_q, rop_q, qneg_q, rneg_q, dz_q;

    logic [WIDTH-1:0] mag1, mag2, diff;
    logic [WIDTH:0]   sh_full;
    logic             borrow, dsr_zero, early;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    // The shifted partial remainder can reach WIDTH+1 bits when the divisor exceeds 2^(WIDTH-1)
    always_comb begin
        mag1     = mag(dvd, sgn_q);
        mag2     = mag(dsr, sgn_q);
        dsr_zero = (dsr == '0);
        sh_full  = {rem, dvd[WIDTH-1]};
        borrow   = (sh_full < {1'b0, dsr});
        diff     = sh_full[WIDTH-1:0] - dsr;
`ifdef DIV_EARLY_OUT_EN
        early    = (mag1 < mag2);
`else
        early    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        div_zero  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = resetn;
                busy     = 1'b0;
                if (in_valid) state_nxt = PREP;
            end
            PREP: begin
                if (dsr_zero || early) state_nxt = FIX;
                else                   state_nxt = ITER;
            end
            ITER: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                div_zero  = dz_q;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            res_q  <= '0;
            sgn_q  <= 1'b0;
            rop_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (flush) begin
            dz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd   <= src1;
                        dsr   <= src2;
                        sgn_q <= op_signed;
                        rop_q <= op_rem;
                        dz_q  <= 1'b0;
                    end
                end
                PREP: begin
                    qneg_q <= sgn_q & (dvd[WIDTH-1] ^ dsr[WIDTH-1]);
                    rneg_q <= sgn_q & dvd[WIDTH-1];
                    if (dsr_zero) begin
                        dvd  <= '1;
                        rem  <= dvd;
                        dz_q <= 1'b1;
                    end else if (early) begin
                        dvd <= '0;
                        rem <= mag1;
                        dsr <= mag2;
                    end else begin
                        dvd <= mag1;
                        dsr <= mag2;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                ITER: begin
                    rem <= borrow ? sh_full[WIDTH-1:0] : diff;
                    dvd <= {dvd[WIDTH-2:0], ~borrow};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (dz_q)       res_q <= rop_q ? rem : dvd;
                    else if (rop_q) res_q <= rneg_q ? neg(rem) : rem;
                    else            res_q <= qneg_q ? neg(dvd) : dvd;
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus random ops against an arithmetic model.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn, in_valid, in_ready, op_signed, op_rem, flush;
    logic         out_valid, out_ready, busy, div_zero;
    logic [W-1:0] src1, src2, result;

    int n_chk  = 0;
    int n_pass = 0;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op_signed(op_signed), .op_rem(op_rem), .src1(src1), .src2(src2),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // LoongArch truncating division: quotient toward zero, remainder takes dividend's sign
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, input logic rsel,
                                  output logic [W-1:0] res, output logic dz, output int lat);
        longint sa, sb, q, r;
        sa = (sgn && a[W-1]) ? longint'(a) - (longint'(1) << W) : longint'(a);
        sb = (sgn && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
        if (b == '0) begin
            q   = longint'({W{1'b1}});
            r   = longint'(a);
            dz  = 1'b1;
            lat = 3;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            dz  = 1'b0;
            lat = W + 3;
`ifdef DIV_EARLY_OUT_EN
            if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) lat = 3;
`endif
        end
        res = rsel ? r[W-1:0] : q[W-1:0];
    endfunction

    // Caller is at a negedge; the op is accepted at the next posedge (cycle 0)
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic rsel, input int hold);
        logic [W-1:0] er;
        logic         edz;
        int           elat, lat;
        model(a, b, sgn, rsel, er, edz, elat);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; src1 = a; src2 = b; op_signed = sgn; op_rem = rsel;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; src1 = $urandom; src2 = $urandom;
        op_signed = $urandom_range(0, 1); op_rem = $urandom_range(0, 1);
        lat = 1;
        check("busy_after_accept", busy, 1);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, elat);
        check("result", result, er);
        check("div_zero", div_zero, edz);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_state", {out_valid, busy, in_ready}, 3'b110);
            check("hold_result", result, er);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("released", {out_valid, busy, in_ready, div_zero}, 4'b0010);
    endtask

    initial begin
        int lat;
        logic [W-1:0] a, b;
        resetn = 1'b0; in_valid = 1'b0; op_signed = 1'b0; op_rem = 1'b0;
        flush = 1'b0; out_ready = 1'b0; src1 = '0; src2 = '0;
        #1;
        check("reset_outputs", {in_ready, out_valid, busy, div_zero}, 4'b0000);
        check("reset_result", result, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {in_ready, busy}, 2'b10);

        run_op(32'd7, 32'd2, 1'b0, 1'b0, 0);
        run_op(32'd7, 32'd2, 1'b0, 1'b1, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 0);
        run_op(32'h0000_1234, 32'd0, 1'b1, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 5);
        run_op(32'd3, 32'd10, 1'b0, 1'b0, 0);
        run_op(32'd3, 32'd10, 1'b0, 1'b1, 0);

        // flush mid-iteration, then a fresh op right behind it
        check("flush_ready", in_ready, 1);
        in_valid = 1'b1; src1 = 32'd1234567; src2 = 32'd3; op_signed = 1'b0; op_rem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("after_flush", {out_valid, busy, in_ready, div_zero}, 4'b0010);
        run_op(32'd100, 32'd7, 1'b0, 1'b0, 0);
        run_op(32'd100, 32'd7, 1'b0, 1'b1, 0);

        // flush wins over a simultaneous request
        in_valid = 1'b1; flush = 1'b1; src1 = 32'd9; src2 = 32'd4;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_beats_valid", {busy, in_ready}, 2'b01);

        // asynchronous reset in the middle of an iteration
        in_valid = 1'b1; src1 = 32'd500; src2 = 32'd3; op_signed = 1'b0; op_rem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", {in_ready, out_valid, busy, div_zero}, 4'b0000);
        check("async_reset_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset2", {in_ready, busy}, 2'b10);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 7))
                0:       begin a = $urandom; b = '0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom; b = W'($urandom_range(1, 15)); end
                3:       begin a = W'($urandom_range(0, 100)); b = $urandom; end
                4:       begin a = $urandom; b = -W'($urandom_range(1, 9)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
